// File: rtl/bpsk_tx_shaper_pkg.sv
// Shared types and constants for the BPSK transmit shaper.
package tx_pkg;

  localparam int SAMPLE_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_TAIL
  } tx_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/bpsk_tx_shaper_interp.sv
// Linear-ramp interpolator between the previous and current symbol targets.
module tx_ramp_interp
  import tx_pkg::*;
#(
  parameter int SPS = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_sample_en,
  input  logic [clog2(SPS)-1:0]      i_phase,
  input  logic [SAMPLE_W-1:0]        i_prev,
  input  logic [SAMPLE_W-1:0]        i_cur,
  output logic [SAMPLE_W-1:0]        o_data
);

  localparam int PW     = clog2(SPS);
  localparam int PROD_W = SAMPLE_W + PW + 2;

  logic signed [SAMPLE_W-1:0] r_data;

  // Floor-shifted ramp; at the last phase step == SPS so the result is cur exactly.
  function automatic logic signed [SAMPLE_W-1:0] ramp_point(
    input logic signed [SAMPLE_W-1:0] prev,
    input logic signed [SAMPLE_W-1:0] cur,
    input logic        [PW-1:0]       phase
  );
    logic signed [SAMPLE_W:0]  diff;
    logic signed [PW+1:0]      step;
    logic signed [PROD_W-1:0]  prod;
    diff = (SAMPLE_W+1)'(cur) - (SAMPLE_W+1)'(prev);
    step = $signed((PW+2)'(phase) + (PW+2)'(1));
    prod = PROD_W'(diff) * PROD_W'(step);
    return SAMPLE_W'((prod >>> PW) + PROD_W'(prev));
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data <= '0;
    end else if (i_sample_en) begin
      r_data <= ramp_point($signed(i_prev), $signed(i_cur), i_phase);
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/bpsk_tx_shaper.sv
// BPSK transmit shaper: byte handshake, preamble/data/tail framing, NRZ mapping
// and linear-ramp upsampling to SPS samples per symbol.
module bpsk_tx_shaper
  import tx_pkg::*;
#(
  parameter int SPS          = 8,
  parameter int PREAMBLE_LEN = 16,
  parameter int AMP          = 65536
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                sample_en,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic [SAMPLE_W-1:0] data_out,
  output logic                sym_strobe,
  output logic                busy
);

  localparam int                          PW         = clog2(SPS);
  localparam logic        [PW-1:0]        LAST_PHASE = PW'(SPS - 1);
  localparam logic        [7:0]           PRE_LAST   = 8'(PREAMBLE_LEN);
  localparam logic signed [SAMPLE_W-1:0]  POS_AMP    = SAMPLE_W'(AMP);
  localparam logic signed [SAMPLE_W-1:0]  NEG_AMP    = -POS_AMP;

  function automatic logic signed [SAMPLE_W-1:0] bit_target(input logic b);
    return b ? POS_AMP : NEG_AMP;
  endfunction

  tx_state_t                  r_state;
  logic [PW-1:0]              r_phase;
  logic signed [SAMPLE_W-1:0] r_prev;
  logic signed [SAMPLE_W-1:0] r_cur;
  logic [7:0]                 r_hold;
  logic                       r_full;
  logic [7:0]                 r_shift;
  logic [2:0]                 r_bit_cnt;
  logic [7:0]                 r_pre_cnt;
  logic                       r_strobe;

  logic                       w_boundary;
  logic                       w_accept;
  tx_state_t                  w_state_nxt;
  logic signed [SAMPLE_W-1:0] w_target;
  logic [7:0]                 w_pre_nxt;
  logic [2:0]                 w_bit_nxt;
  logic                       w_load;
  logic                       w_shift;

  assign w_boundary = sample_en && (r_phase == LAST_PHASE);
  assign w_accept   = byte_valid && !r_full;

  // Next-symbol decision; only consumed on a symbol boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_target    = '0;
    w_pre_nxt   = r_pre_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_full) begin
          w_state_nxt = ST_PREAMBLE;
          w_target    = POS_AMP;
          w_pre_nxt   = 8'd1;
        end
      end
      ST_PREAMBLE: begin
        if (r_pre_cnt == PRE_LAST) begin
          w_state_nxt = ST_DATA;
          w_load      = 1'b1;
          w_target    = bit_target(r_hold[7]);
          w_bit_nxt   = 3'd0;
        end else begin
          w_pre_nxt = r_pre_cnt + 8'd1;
          w_target  = r_pre_cnt[0] ? NEG_AMP : POS_AMP;
        end
      end
      ST_DATA: begin
        if (r_bit_cnt == 3'd7) begin
          if (r_full) begin
            w_load    = 1'b1;
            w_target  = bit_target(r_hold[7]);
            w_bit_nxt = 3'd0;
          end else begin
            w_state_nxt = ST_TAIL;
          end
        end else begin
          w_shift   = 1'b1;
          w_target  = bit_target(r_shift[7]);
          w_bit_nxt = r_bit_cnt + 3'd1;
        end
      end
      ST_TAIL: begin
        w_state_nxt = ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_prev    <= '0;
      r_cur     <= '0;
      r_full    <= 1'b0;
      r_bit_cnt <= '0;
      r_pre_cnt <= '0;
      r_strobe  <= 1'b0;
    end else begin
      r_strobe <= w_boundary;
      if (sample_en) begin
        r_phase <= (r_phase == LAST_PHASE) ? '0 : r_phase + PW'(1);
      end
      if (w_boundary) begin
        r_state   <= w_state_nxt;
        r_prev    <= r_cur;
        r_cur     <= w_target;
        r_pre_cnt <= w_pre_nxt;
        r_bit_cnt <= w_bit_nxt;
      end
      // A load frees the holding register; an accept can only happen while it is empty.
      if (w_boundary && w_load) begin
        r_full <= 1'b0;
      end else if (w_accept) begin
        r_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold <= byte_in;
    end
    if (w_boundary) begin
      if (w_load) begin
        r_shift <= {r_hold[6:0], 1'b0};
      end else if (w_shift) begin
        r_shift <= {r_shift[6:0], 1'b0};
      end
    end
  end

  tx_ramp_interp #(
    .SPS (SPS)
  ) u_interp (
    .clk         (clk),
    .resetn      (resetn),
    .i_sample_en (sample_en),
    .i_phase     (r_phase),
    .i_prev      (r_prev),
    .i_cur       (r_cur),
    .o_data      (data_out)
  );

  assign byte_ready = !r_full;
  assign sym_strobe = r_strobe;
  assign busy       = (r_state != ST_IDLE);

endmodule
